// File: rtl/if_fetch_queue_if.sv
// Fetch-queue bus: instruction-memory request/response, downstream redirect,
// and the valid/ready handoff to decode.
interface if_fetch_queue_if #(
    parameter int WIDTH = 32
);
    logic             imem_req;
    logic [WIDTH-1:0] imem_addr;
    logic [WIDTH-1:0] imem_rdata;
    logic             redirect;
    logic [WIDTH-1:0] redirect_pc;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_instr;
    logic [WIDTH-1:0] out_pc;

    // master: the fetch queue itself
    modport master (
        output imem_req, imem_addr, out_valid, out_instr, out_pc,
        input  imem_rdata, redirect, redirect_pc, out_ready
    );

    // slave: memory + decode side
    modport slave (
        input  imem_req, imem_addr, out_valid, out_instr, out_pc,
        output imem_rdata, redirect, redirect_pc, out_ready
    );
endinterface

// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: owns the PC, issues one-cycle-latency fetches
// and buffers {instr, pc} pairs in a small circular queue ahead of decode.
module if_fetch_queue #(
    parameter int               WIDTH    = 32,
    parameter int               DEPTH    = 2,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    if_fetch_queue_if.master  fq
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 2;

    typedef struct packed {
        logic [WIDTH-1:0] instr;
        logic [WIDTH-1:0] pc;
    } entry_t;

    entry_t           mem_q [DEPTH];
    entry_t           mem_d [DEPTH];
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] inflight_pc_q, inflight_pc_d;
    logic             inflight_q, inflight_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    logic             head_valid;
    logic             pop;
    logic             push;
    logic             req;
    logic [CW-1:0]    occupancy;

    // Head outputs and request decision; redirect masks both the pop and the fetch.
    always_comb begin
        head_valid   = (count_q != '0);
        fq.out_valid = head_valid & ~fq.redirect;
        fq.out_instr = head_valid ? mem_q[rd_ptr_q].instr : '0;
        fq.out_pc    = head_valid ? mem_q[rd_ptr_q].pc    : '0;
        pop          = fq.out_valid & fq.out_ready;
        push         = inflight_q & ~fq.redirect;
        // Slots already committed (queued + in flight) after this cycle's pop.
        occupancy    = count_q + CW'(inflight_q) - CW'(pop);
        req          = ~reset & ~fq.redirect & (occupancy < CW'(DEPTH));
        fq.imem_req  = req;
        fq.imem_addr = pc_q;
    end

    always_comb begin
        pc_d          = pc_q;
        inflight_d    = inflight_q;
        inflight_pc_d = inflight_pc_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        mem_d         = mem_q;
        if (fq.redirect) begin
            pc_d       = fq.redirect_pc;
            inflight_d = 1'b0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            inflight_d = req;
            if (req) begin
                pc_d          = pc_q + WIDTH'(4);
                inflight_pc_d = pc_q;
            end
            if (push) begin
                mem_d[wr_ptr_q] = '{instr: fq.imem_rdata, pc: inflight_pc_q};
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            mem_q         <= mem_d;
        end
    end
endmodule
